// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op encodings, memory write modes,
// controller states and the address legality helpers used at CHECK.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SB  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        WM_NONE = 2'd0,
        WM_BYTE = 2'd1,
        WM_HALF = 2'd2,
        WM_WORD = 2'd3
    } write_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD_WAIT,
        ST_STORE_WAIT,
        ST_RELEASE,
        ST_RESP
    } lsu_state_e;

    // Addressable memory is 256 KiB; any bit at or above this one is out of range.
    localparam int ADDR_LIMIT_BIT = 18;

    function automatic logic is_store(lsu_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Access width doubles as the write mode a store of that width drives.
    function automatic write_mode_e access_size(lsu_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return WM_BYTE;
            OP_LH, OP_LHU, OP_SH: return WM_HALF;
            default:              return WM_WORD;
        endcase
    endfunction

    function automatic logic access_fault(lsu_op_e op, logic [31:0] addr);
        logic misaligned;
        misaligned = ((access_size(op) == WM_HALF) && addr[0]) ||
                     ((access_size(op) == WM_WORD) && (addr[1:0] != 2'b00));
        return misaligned || (addr[31:ADDR_LIMIT_BIT] != '0);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data path: picks the memory read port matching the access width and
// sign- or zero-extends it to 32 bits.
module lsu_extend
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [7:0]  byte_data,
    input  logic [15:0] half_data,
    input  logic [31:0] word_data,
    output logic [31:0] load_data
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves load_data unassigned (no latch).
        load_data = word_data;
        case (op)
            OP_LB:   load_data = {{24{byte_data[7]}}, byte_data};
            OP_LBU:  load_data = {24'h0, byte_data};
            OP_LH:   load_data = {{16{half_data[15]}}, half_data};
            OP_LHU:  load_data = {16'h0, half_data};
            default: load_data = word_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller: checks alignment and range,
// waits a fixed read latency for loads and a done handshake for stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,

    output logic [31:0] mem_address,
    output logic [1:0]  mem_write_mode,
    output logic [7:0]  mem_write_byte,
    output logic [15:0] mem_write_half_word,
    output logic [31:0] mem_write_word,
    input  logic        mem_done,
    input  logic        mem_error,
    input  logic [7:0]  mem_byte_output,
    input  logic [15:0] mem_half_word_output,
    input  logic [31:0] mem_word_output
);

    localparam int CNT_MAX = (TIMEOUT > READ_LATENCY) ? TIMEOUT : READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state;
    lsu_op_e          op_q;
    logic [31:0]      wdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      load_data;

    lsu_extend u_extend (
        .op        (op_q),
        .byte_data (mem_byte_output),
        .half_data (mem_half_word_output),
        .word_data (mem_word_output),
        .load_data (load_data)
    );

    // A memory still finishing an earlier (possibly reset-interrupted) write holds off new requests.
    assign req_ready = (state == ST_IDLE) && !mem_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            op_q                <= OP_LB;
            wdata_q             <= '0;
            err_q               <= 1'b0;
            cnt                 <= '0;
            resp_valid          <= 1'b0;
            resp_data           <= '0;
            resp_error          <= 1'b0;
            mem_address         <= '0;
            mem_write_mode      <= WM_NONE;
            mem_write_byte      <= '0;
            mem_write_half_word <= '0;
            mem_write_word      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            resp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q        <= lsu_op_e'(req_op);
                        mem_address <= req_addr;
                        wdata_q     <= req_wdata;
                        err_q       <= 1'b0;
                        state       <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    cnt <= '0;
                    if (access_fault(op_q, mem_address)) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_data  <= '0;
                        state      <= ST_RESP;
                    end else if (is_store(op_q)) begin
                        mem_write_mode      <= access_size(op_q);
                        mem_write_byte      <= (access_size(op_q) == WM_BYTE) ? wdata_q[7:0]  : '0;
                        mem_write_half_word <= (access_size(op_q) == WM_HALF) ? wdata_q[15:0] : '0;
                        mem_write_word      <= (access_size(op_q) == WM_WORD) ? wdata_q       : '0;
                        state               <= ST_STORE_WAIT;
                    end else begin
                        state <= ST_LOAD_WAIT;
                    end
                end

                // Read data is sampled once the address has been stable for READ_LATENCY cycles past its launch.
                ST_LOAD_WAIT: begin
                    if (mem_error) err_q <= 1'b1;
                    if (cnt == RL_LAST) begin
                        resp_valid <= 1'b1;
                        resp_error <= err_q || mem_error;
                        resp_data  <= (err_q || mem_error) ? '0 : load_data;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_STORE_WAIT: begin
                    if (mem_error) err_q <= 1'b1;
                    if (mem_done) begin
                        mem_write_mode <= WM_NONE;
                        cnt            <= '0;
                        state          <= ST_RELEASE;
                    end else if (cnt == TO_LAST) begin
                        mem_write_mode <= WM_NONE;
                        resp_valid     <= 1'b1;
                        resp_error     <= 1'b1;
                        resp_data      <= '0;
                        state          <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (!mem_done) begin
                        resp_valid <= 1'b1;
                        resp_error <= err_q;
                        resp_data  <= '0;
                        state      <= ST_RESP;
                    end else if (cnt == TO_LAST) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_data  <= '0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RESP: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a behavioural memory responder and a
// per-transaction expectation model derived from the access rules.
module tb_load_store_unit;

    localparam int RL = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [1:0]  mem_write_mode;
    logic [7:0]  mem_write_byte;
    logic [15:0] mem_write_half_word;
    logic [31:0] mem_write_word;
    logic        mem_done;
    logic        mem_error;
    logic [7:0]  mem_byte_output;
    logic [15:0] mem_half_word_output;
    logic [31:0] mem_word_output;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(.READ_LATENCY(RL), .TIMEOUT(TO)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_op               (req_op),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .resp_valid           (resp_valid),
        .resp_data            (resp_data),
        .resp_error           (resp_error),
        .mem_address          (mem_address),
        .mem_write_mode       (mem_write_mode),
        .mem_write_byte       (mem_write_byte),
        .mem_write_half_word  (mem_write_half_word),
        .mem_write_word       (mem_write_word),
        .mem_done             (mem_done),
        .mem_error            (mem_error),
        .mem_byte_output      (mem_byte_output),
        .mem_half_word_output (mem_half_word_output),
        .mem_word_output      (mem_word_output)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int access_bytes(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd4 || op == 3'd3) return 1;
        if (op == 3'd1 || op == 3'd5 || op == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [7:0] b,
                                               input logic [15:0] h, input logic [31:0] w);
        case (op)
            3'd0:    return (b < 8'd128) ? 32'(b) : 32'(b) + 32'hFFFF_FF00;
            3'd1:    return (h < 16'd32768) ? 32'(h) : 32'(h) + 32'hFFFF_0000;
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // rise: write cycles before done is seen (0 = never); fall: cycles done lingers after write ends (-1 = never).
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [7:0] b, input logic [15:0] h, input logic [31:0] w,
                           input bit merr, input int rise, input int fall);
        bit          store;
        bit          fault;
        int          size;
        int          exp_lat, exp_wm;
        logic [31:0] exp_data, exp_port, got_port;
        bit          exp_err;
        int          got_lat, wm_cnt, wm_bad, wseen, rel;
        bit          addr_bad, seen_port;
        logic [31:0] got_data;
        logic        got_err;

        size  = access_bytes(op);
        store = op inside {3'd3, 3'd6, 3'd7};
        fault = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00) || (addr >= 32'h0004_0000);
        exp_data = 32'h0;
        exp_wm   = 0;
        exp_port = (size == 1) ? (wdata & 32'hFF) : (size == 2) ? (wdata & 32'hFFFF) : wdata;
        if (fault) begin
            exp_lat = 2;
            exp_err = 1'b1;
        end else if (!store) begin
            exp_lat  = RL + 3;
            exp_err  = merr;
            exp_data = merr ? 32'h0 : model_load(op, b, h, w);
        end else if (rise == 0) begin
            exp_wm  = TO;
            exp_lat = TO + 2;
            exp_err = 1'b1;
        end else if (fall < 0 || fall + 1 > TO) begin
            exp_wm  = rise;
            exp_lat = rise + TO + 2;
            exp_err = 1'b1;
        end else begin
            exp_wm  = rise;
            exp_lat = rise + fall + 3;
            exp_err = merr;
        end

        mem_byte_output      = b;
        mem_half_word_output = h;
        mem_word_output      = w;
        mem_error            = merr;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        check("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_op    = 3'($urandom);

        got_lat = 0; wm_cnt = 0; wm_bad = 0; wseen = 0; rel = 0;
        addr_bad = 1'b0; seen_port = 1'b0; got_port = 32'h0;
        got_data = 32'h0; got_err = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (mem_address !== addr) addr_bad = 1'b1;
            if (mem_write_mode != 2'd0) begin
                if (32'(mem_write_mode) == ((size == 4) ? 32'd3 : 32'(size))) wm_cnt++;
                else wm_bad++;
                if (!seen_port) begin
                    seen_port = 1'b1;
                    got_port  = (mem_write_mode == 2'd1) ? 32'(mem_write_byte) :
                                (mem_write_mode == 2'd2) ? 32'(mem_write_half_word) : mem_write_word;
                end
                wseen++;
                if (rise != 0 && wseen == rise) mem_done = 1'b1;
            end else if (mem_done) begin
                rel++;
                if (fall >= 0 && rel == fall + 1) mem_done = 1'b0;
            end
            if (resp_valid) begin
                got_lat  = cyc;
                got_data = resp_data;
                got_err  = resp_error;
                break;
            end
            @(negedge clk);
        end

        check("resp_latency", 32'(got_lat), 32'(exp_lat));
        check("resp_data", got_data, exp_data);
        check("resp_error", 32'(got_err), 32'(exp_err));
        check("write_cycles", 32'(wm_cnt), 32'(exp_wm));
        check("write_mode_value", 32'(wm_bad), 32'd0);
        check("addr_stable", 32'(addr_bad), 32'd0);
        if (seen_port) check("write_port", got_port, exp_port);

        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 32'd0);
        if (mem_done) begin
            check("ready_blocked_by_done", 32'(req_ready), 32'd0);
            mem_done = 1'b0;
            #1;
            check("ready_after_done_low", 32'(req_ready), 32'd1);
            @(negedge clk);
        end else begin
            check("ready_after_resp", 32'(req_ready), 32'd1);
        end
        mem_error = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        int          sel, size;

        req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_done = 1'b0; mem_error = 1'b0;
        mem_byte_output = 8'h0; mem_half_word_output = 16'h0; mem_word_output = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_write_mode", 32'(mem_write_mode), 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(3'd0, 32'h103, 32'h0, 8'h80, 16'h1234, 32'h5555_AAAA, 1'b0, 1, 0);
        run_txn(3'd5, 32'h102, 32'h0, 8'h11, 16'h8001, 32'h0, 1'b0, 1, 0);
        run_txn(3'd7, 32'h101, 32'hDEAD_BEEF, 8'h0, 16'h0, 32'h0, 1'b0, 1, 0);
        run_txn(3'd6, 32'h200, 32'h0000_BEEF, 8'h0, 16'h0, 32'h0, 1'b0, 3, 1);
        run_txn(3'd3, 32'h040, 32'h0000_00A5, 8'h0, 16'h0, 32'h0, 1'b0, 0, 0);
        run_txn(3'd7, 32'h300, 32'h1234_5678, 8'h0, 16'h0, 32'h0, 1'b0, 2, -1);
        run_txn(3'd2, 32'h0004_0000, 32'h0, 8'h0, 16'h0, 32'h0, 1'b0, 1, 0);
        run_txn(3'd1, 32'h3FFFE, 32'h0, 8'h0, 16'hFFFE, 32'h0, 1'b1, 1, 0);

        // Reset in the middle of a store that the memory never acknowledges.
        req_op = 3'd3; req_addr = 32'h44; req_wdata = 32'h5A; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wm_before_reset", 32'(mem_write_mode), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_write_mode", 32'(mem_write_mode), 32'd0);
        check("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("async_rst_resp_data", resp_data, 32'h0);
        check("async_rst_resp_error", 32'(resp_error), 32'd0);
        check("async_rst_mem_address", mem_address, 32'h0);
        check("async_rst_write_byte", 32'(mem_write_byte), 32'h0);
        check("async_rst_write_half", 32'(mem_write_half_word), 32'h0);
        check("async_rst_write_word", mem_write_word, 32'h0);
        check("async_rst_ready", 32'(req_ready), 32'd1);
        mem_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_held", 32'(req_ready), 32'd0);
        mem_done = 1'b0;
        @(negedge clk);
        check("post_rst_ready_free", 32'(req_ready), 32'd1);

        for (int t = 0; t < 80; t++) begin
            op   = 3'($urandom_range(0, 7));
            size = access_bytes(op);
            sel  = $urandom_range(0, 9);
            if (sel == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, 32'h3FFFF));
            if (sel >= 1 && sel <= 6) addr = addr & ~32'(size - 1);
            run_txn(op, addr, $urandom, 8'($urandom), 16'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
